// File: rtl/load_store_unit.sv
// Load/store stage: validates a memory op, runs a req/ack access to a word-organised RAM,
// steers store bytes onto lanes and sign/zero-extends load data.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              we,
    input  logic [2:0]        memop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TO_CNT = TIMEOUT[7:0];
    localparam bit         TO_EN  = (TIMEOUT != 0);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [2:0]  op_reg;
    logic [1:0]  off_reg;
    logic        store_reg;

    logic        op_illegal;
    logic        op_misaligned;
    logic        req_bad;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        timeout_hit;

    // Request checks are made on the live inputs, in the same cycle start is accepted.
    always_comb begin
        op_illegal    = (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111)
                        || (we && memop[2]);
        op_misaligned = ((memop[1:0] == 2'b01) && addr[0])
                        || ((memop == 3'b010) && (addr[1:0] != 2'b00));
        req_bad       = op_illegal || op_misaligned;
    end

    // Per-lane store steering: each lane picks the replicated byte/half or its own word byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wdata[gi*8 +: 8] =
                (memop[1:0] == 2'b00) ? wdata[7:0] :
                (memop[1:0] == 2'b01) ? wdata[(gi%2)*8 +: 8] :
                                        wdata[gi*8 +: 8];
            assign lane_mask[gi] =
                (memop[1:0] == 2'b00) ? (addr[1:0] == 2'(gi)) :
                (memop[1:0] == 2'b01) ? (addr[1] == 1'(gi/2)) :
                                        1'b1;
        end
    endgenerate

    // Load extraction uses the op and offset latched at accept time.
    always_comb begin
        ld_byte = mem_rdata[{off_reg, 3'b000} +: 8];
        ld_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_reg)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    assign timeout_hit = TO_EN && ((cnt_reg + 8'd1) == TO_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
            op_reg    <= 3'd0;
            off_reg   <= 2'd0;
            store_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= memop;
                        off_reg   <= addr[1:0];
                        store_reg <= we;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        if (req_bad) begin
                            err       <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= we;
                            mem_addr  <= addr[ADDR_W-1:2];
                            mem_wdata <= lane_wdata;
                            mem_wmask <= we ? lane_mask : 4'd0;
                            cnt_reg   <= 8'd0;
                            state_reg <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wmask <= 4'd0;
                        if (!store_reg) begin
                            rdata <= ld_ext;
                        end
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wmask <= 4'd0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    mem_req   <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model predicts every cycle of each op,
// a negedge process compares the DUT, plus fixed directed cases with literal expectations.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  memop = 3'b111;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .we(we), .memop(memop), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle, and the model's architectural state.
    logic        e_busy = 0, e_done = 0, e_err = 0, e_req = 0, e_we = 0;
    logic [29:0] e_maddr = 0;
    logic [3:0]  e_mask = 0;
    logic [31:0] e_mwdata = 0, e_rdata = 0;
    logic        m_err = 0;
    logic [31:0] m_rdata = 0;

    // Observations of the most recent transaction, for the directed literal checks.
    logic [3:0]  obs_mask;
    logic [31:0] obs_mwdata;
    logic [29:0] obs_maddr;
    logic        obs_mwe, obs_done, obs_err;
    int          obs_reqcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_err));
            chk("rdata", rdata, e_rdata);
            chk("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
                chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
                if (e_we) chk("mem_wdata", mem_wdata, e_mwdata);
            end
        end
    end

    function automatic logic m_bad(input logic w, input logic [2:0] op, input logic [1:0] a);
        if (op == 3 || op == 6 || op == 7) return 1'b1;
        if (w && op >= 4) return 1'b1;
        if ((op == 1 || op == 5) && a[0]) return 1'b1;
        if (op == 2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_size(input logic [2:0] op);
        if (op == 2) return 4;
        if (op == 1 || op == 5) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] word);
        int unsigned v;
        int sz;
        sz = m_size(op);
        if (sz == 4) return word;
        v = word >> (8 * int'(a));
        v = (sz == 1) ? v % 256 : v % 65536;
        if (op < 4) begin
            if (sz == 1 && v >= 128) v = v - 256;
            if (sz == 2 && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [1:0] a);
        int sz;
        sz = m_size(op);
        if (sz == 4) return 4'hF;
        if (sz == 2) return 4'(3 << int'(a));
        return 4'(1 << int'(a));
    endfunction

    function automatic logic [31:0] m_wlanes(input logic [2:0] op, input logic [31:0] w);
        int sz;
        sz = m_size(op);
        if (sz == 4) return w;
        if (sz == 2) return (w % 65536) * 32'h0001_0001;
        return (w % 256) * 32'h0101_0101;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        e_busy = 0; e_done = 0; e_req = 0; e_err = m_err; e_rdata = m_rdata;
    endtask

    // Inputs that must be ignored while the unit is busy.
    task automatic noise();
        start = 1'($urandom); we = 1'($urandom); memop = 3'($urandom);
        addr = $urandom; wdata = $urandom;
    endtask

    task automatic txn(input logic t_we, input logic [2:0] t_op, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input int ack_lat, input logic [31:0] t_word);
        logic bad, tout;
        int nreq;
        bad  = m_bad(t_we, t_op, t_addr[1:0]);
        tout = 1'b0;
        obs_reqcnt = 0;
        start = 1; we = t_we; memop = t_op; addr = t_addr; wdata = t_wdata;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        tick();
        if (!bad) begin
            tout = (ack_lat + 1 > TO);
            nreq = tout ? TO : ack_lat + 1;
            for (int k = 1; k <= nreq; k++) begin
                e_busy = 1; e_done = 0; e_err = 0; e_req = 1; e_we = t_we;
                e_maddr = t_addr[31:2]; e_mask = t_we ? m_mask(t_op, t_addr[1:0]) : 4'd0;
                e_mwdata = m_wlanes(t_op, t_wdata); e_rdata = m_rdata;
                if (k == 1) begin
                    obs_mask = mem_wmask; obs_mwdata = mem_wdata;
                    obs_maddr = mem_addr; obs_mwe = mem_we;
                end
                if (mem_req) obs_reqcnt++;
                noise();
                mem_ack = (!tout && k == nreq);
                mem_rdata = mem_ack ? t_word : $urandom;
                tick();
            end
        end
        m_err = bad || tout;
        if (!bad && !tout && !t_we) m_rdata = m_load(t_op, t_addr[1:0], t_word);
        e_busy = 1; e_done = 1; e_req = 0; e_err = m_err; e_rdata = m_rdata;
        obs_done = done; obs_err = err;
        if (mem_req) obs_reqcnt++;
        noise();
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        tick();
        start = 0; mem_ack = 0;
        set_idle();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1;
        set_idle();
        chk_en = 1;
        tick();

        // lw with ack three cycles after the request
        txn(0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF);
        chk("t1 mem_addr", 32'(obs_maddr), 32'h4);
        chk("t1 done@ack+1", 32'(obs_done), 32'd1);
        chk("t1 rdata", rdata, 32'hDEADBEEF);
        chk("t1 err", 32'(err), 32'd0);

        // byte loads, signed and unsigned, minimum latency
        txn(0, 3'b000, 32'h13, 32'h0, 0, 32'h80FF_FF7F);
        chk("t2 lb", rdata, 32'hFFFFFF80);
        txn(0, 3'b100, 32'h13, 32'h0, 1, 32'h80FF_FF7F);
        chk("t2 lbu", rdata, 32'h00000080);

        // store lane steering
        txn(1, 3'b000, 32'h6, 32'h12345678, 2, 32'h0);
        chk("t3 sb mask", 32'(obs_mask), 32'b0100);
        chk("t3 sb data", obs_mwdata, 32'h78787878);
        chk("t3 sb we", 32'(obs_mwe), 32'd1);
        chk("t3 sb keeps rdata", rdata, 32'h00000080);
        txn(1, 3'b001, 32'h6, 32'h12345678, 0, 32'h0);
        chk("t3 sh mask", 32'(obs_mask), 32'b1100);
        chk("t3 sh data", obs_mwdata, 32'h56785678);

        // rejected ops: done one cycle after start, no request
        txn(0, 3'b010, 32'h2, 32'h0, 0, 32'h0);
        chk("t4 lw mis done", 32'(obs_done), 32'd1);
        chk("t4 lw mis err", 32'(obs_err), 32'd1);
        chk("t4 lw mis req", 32'(obs_reqcnt), 32'd0);
        txn(0, 3'b001, 32'h1, 32'h0, 0, 32'h0);
        chk("t4 lh mis err", 32'(obs_err), 32'd1);
        txn(0, 3'b111, 32'h0, 32'h0, 0, 32'h0);
        chk("t4 none err", 32'(obs_err), 32'd1);
        chk("t4 none req", 32'(obs_reqcnt), 32'd0);
        chk("t4 rdata held", rdata, 32'h00000080);

        // timeout, with ignored start pulses while busy
        txn(0, 3'b010, 32'h20, 32'h0, 100, 32'h0);
        chk("t5 req cycles", 32'(obs_reqcnt), 32'd4);
        chk("t5 err", 32'(obs_err), 32'd1);
        chk("t5 done", 32'(obs_done), 32'd1);

        // randomized ops
        for (int n = 0; n < 300; n++) begin
            txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom_range(0, 5), $urandom);
            repeat ($urandom_range(0, 2)) begin
                mem_ack = 1'($urandom);
                tick();
            end
            mem_ack = 0;
        end

        // asynchronous reset in the middle of an access
        chk_en = 0;
        start = 1; we = 0; memop = 3'b010; addr = 32'h40;
        tick();
        start = 0; mem_ack = 0;
        tick();
        #1 rst_n = 0;
        #1;
        chk("t6 mem_req", 32'(mem_req), 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1;
        m_err = 0; m_rdata = 0;
        set_idle();
        chk("t6 rdata cleared", rdata, 32'd0);
        chk_en = 1;
        tick();
        txn(0, 3'b010, 32'h44, 32'h0, 1, 32'hCAFEF00D);
        chk("t6 lw after rst", rdata, 32'hCAFEF00D);
        chk("t6 err after rst", 32'(err), 32'd0);
        tick();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
